// File: rtl/cbb_ecc_pkg.sv
// Shared types and code-construction helpers for the SEC-DED scrubber and its codec.
// Codeword layout: {overall parity, check[EW-2:0], data[DW-1:0]}.
package cbb_ecc_pkg;

    localparam int DW_DEF = 64;
    localparam int EW_DEF = 8;
    localparam int CW     = DW_DEF + EW_DEF;

    typedef enum logic [2:0] {IDLE, WAIT, RD, RLAT, CHK, ENC, WR, NEXT} scrub_st_e;

    // Data bit i uses the i-th integer >= 3 that is not a power of two as its H-matrix column.
    function automatic int unsigned hcol(input int i);
        int n;
        int unsigned r;
        n = 0;
        r = 0;
        for (int v = 3; v < 2 * i + 16; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (n == i) r = v;
                n++;
            end
        end
        return r;
    endfunction

    // Data bits covered by check bit j.
    function automatic logic [511:0] hmask(input int dw, input int j);
        logic [511:0] m;
        int n;
        m = '0;
        n = 0;
        for (int v = 3; v < 2 * dw + 16; v++) begin
            if (n < dw && (v & (v - 1)) != 0) begin
                if (v[j]) m[n] = 1'b1;
                n++;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cbb_ecc_dec.sv
// Registered SEC-DED decoder: corrects any single flip, flags even-weight multi-bit errors as DED.
module cbb_ecc_dec
    import cbb_ecc_pkg::*;
#(
    parameter int DW = 64,
    parameter int EW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW+EW-1:0]     din,
    input  logic [DW+EW-1:0]     inj_flip,
    output logic [DW-1:0]        dout,
    output logic                 sec,
    output logic                 ded
);
    localparam int RW = EW - 1;

    logic [DW+EW-1:0] cw;
    logic [RW-1:0]    syn;
    logic [DW-1:0]    flip;
    logic             par;

    assign cw  = din ^ inj_flip;
    assign par = ^cw;

    for (genvar j = 0; j < RW; j++) begin : g_syn
        localparam logic [511:0] M = hmask(DW, j);
        assign syn[j] = cw[DW+j] ^ (^(cw[DW-1:0] & M[DW-1:0]));
    end

    for (genvar i = 0; i < DW; i++) begin : g_flip
        localparam int unsigned H = hcol(i);
        assign flip[i] = (syn == H[RW-1:0]);
    end

    // Odd overall parity means one flip; a flip in a check/parity bit leaves data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
            sec  <= 1'b0;
            ded  <= 1'b0;
        end else begin
            dout <= cw[DW-1:0] ^ (par ? flip : '0);
            sec  <= par;
            ded  <= !par && (syn != '0);
        end
    end

endmodule

// File: rtl/cbb_ecc_enc.sv
// Registered SEC-DED encoder (extended Hamming), one cycle latency.
module cbb_ecc_enc
    import cbb_ecc_pkg::*;
#(
    parameter int DW = 64,
    parameter int EW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        din,
    input  logic [DW+EW-1:0]     inj_flip,
    output logic [DW+EW-1:0]     dout
);
    localparam int RW = EW - 1;

    logic [RW-1:0] chk;

    for (genvar j = 0; j < RW; j++) begin : g_chk
        localparam logic [511:0] M = hmask(DW, j);
        assign chk[j] = ^(din & M[DW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dout <= '0;
        else        dout <= {^{chk, din}, chk, din} ^ inj_flip;
    end

endmodule

// File: rtl/cbb_ecc_scrub.sv
// Background SEC-DED scrubber: reads each word, writes back corrected data on SEC, logs DED.
module cbb_ecc_scrub
    import cbb_ecc_pkg::*;
#(
    parameter int DW       = 64,
    parameter int EW       = 8,
    parameter int AW       = 10,
    parameter int DEPTH    = 1024,
    parameter int INTERVAL = 256,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scrub_en,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW+EW-1:0]     mem_wdata,
    input  logic                 mem_gnt,
    input  logic [DW+EW-1:0]     mem_rdata,
    input  logic                 snp_wr,
    input  logic [AW-1:0]        snp_addr,
    output logic [CNT_W-1:0]     sec_cnt,
    output logic [CNT_W-1:0]     ded_cnt,
    output logic [AW-1:0]        ded_addr,
    output logic                 ded_irq,
    output logic                 pass_done,
    input  logic                 cnt_clr,
    output logic                 busy
);
    localparam int          IW   = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    scrub_st_e       state, nxt;
    logic [AW-1:0]   ptr;
    logic [IW-1:0]   icnt;
    logic            hz_q;
    logic            logged;
    logic [DW-1:0]   corr_q;
    logic [DW-1:0]   dec_dout;
    logic            dec_sec, dec_ded;
    logic            snp_hit;

    cbb_ecc_dec #(.DW(DW), .EW(EW)) u_dec (
        .clk(clk), .rst_n(rst_n), .din(mem_rdata), .inj_flip('0),
        .dout(dec_dout), .sec(dec_sec), .ded(dec_ded)
    );

    cbb_ecc_enc #(.DW(DW), .EW(EW)) u_enc (
        .clk(clk), .rst_n(rst_n), .din(corr_q), .inj_flip('0), .dout(mem_wdata)
    );

    assign snp_hit  = snp_wr && (snp_addr == ptr);
    assign mem_addr = ptr;
    assign busy     = !(state == IDLE || state == WAIT);

    always_comb begin
        nxt       = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ded_irq   = 1'b0;
        pass_done = 1'b0;
        case (state)
            IDLE: if (scrub_en) nxt = (INTERVAL == 0) ? RD : WAIT;
            WAIT: begin
                if (!scrub_en)           nxt = IDLE;
                else if (icnt <= IW'(1)) nxt = RD;
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_gnt) nxt = RLAT;
            end
            RLAT: nxt = CHK;
            CHK: begin
                if (dec_ded) begin
                    ded_irq = 1'b1;
                    nxt     = NEXT;
                end else if (dec_sec) nxt = ENC;
                else                  nxt = NEXT;
            end
            ENC: nxt = WR;
            // A functional write to this word since the read makes our corrected copy stale.
            WR: begin
                if (hz_q) nxt = NEXT;
                else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_gnt) nxt = NEXT;
                end
            end
            NEXT: begin
                pass_done = (ptr == LAST);
                nxt       = scrub_en ? ((INTERVAL == 0) ? RD : WAIT) : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            icnt     <= '0;
            hz_q     <= 1'b0;
            corr_q   <= '0;
            sec_cnt  <= '0;
            ded_cnt  <= '0;
            ded_addr <= '0;
            logged   <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt == WAIT && state != WAIT) icnt <= IW'(INTERVAL);
            else if (state == WAIT)           icnt <= icnt - 1'b1;

            if (state == CHK) corr_q <= dec_dout;

            if (state == NEXT) hz_q <= 1'b0;
            else if (snp_hit && ((state == RD && mem_gnt) || state == RLAT || state == CHK ||
                                 state == ENC || state == WR))
                hz_q <= 1'b1;

            if (state == NEXT) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;

            // Clear wins over a same-cycle increment or log.
            if (cnt_clr) begin
                sec_cnt  <= '0;
                ded_cnt  <= '0;
                ded_addr <= '0;
                logged   <= 1'b0;
            end else if (state == CHK) begin
                if (dec_ded) begin
                    if (ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
                    if (!logged) begin
                        ded_addr <= ptr;
                        logged   <= 1'b1;
                    end
                end else if (dec_sec) begin
                    if (sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cbb_ecc_scrub.md
Name: cbb_ecc_scrub

Overview:
Background scrubber for an SEC-DED protected single-port SRAM holding DW+EW-bit codewords.
- Walks the array one word at a time and checks each codeword with cbb_ecc_dec.
- On a single-bit error, writes back a clean codeword re-encoded by cbb_ecc_enc.
- Counts and logs single-bit and double-bit errors.
- Sits beside the functional memory port behind a priority arbiter; functional traffic always wins.

Parameters:
- DW, 64, data width.
- EW, 8, ECC width (DW+EW = codeword width).
- AW, 10, address width.
- DEPTH, 1024, words scrubbed per pass (must be ≤ 2**AW and ≥ 2).
- INTERVAL, 256, idle cycles between words (0 = back-to-back).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- scrub_en  in  1  enable; level sensitive
- mem_req  out  1  scrubber access request to arbiter
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  AW  access address
- mem_wdata  out  DW+EW  write codeword
- mem_gnt  in  1  arbiter grant; access happens in the cycle mem_req & mem_gnt
- mem_rdata  in  DW+EW  read codeword, valid exactly 1 cycle after a granted read
- snp_wr  in  1  functional write occurring this cycle
- snp_addr  in  AW  address of functional write
- sec_cnt  out  CNT_W  corrected-error count, saturating
- ded_cnt  out  CNT_W  uncorrectable-error count, saturating
- ded_addr  out  AW  address of first DED since reset/clear
- ded_irq  out  1  1-cycle pulse per DED detected
- pass_done  out  1  1-cycle pulse when last address (DEPTH-1) completes
- cnt_clr  in  1  clear counters and ded_addr log
- busy  out  1  high in any state except IDLE/WAIT

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). On reset all outputs are 0, state = IDLE, address pointer = 0, interval counter = 0.
- Decoder and encoder are each registered with 1-cycle latency; their inj_* inputs are tied 0.
- FSM states and transitions:
  - IDLE: if scrub_en, go to WAIT and load the counter with INTERVAL.
  - WAIT: decrement the counter; at 0 go to RD. If INTERVAL=0, go straight to RD.
  - RD: mem_req=1, mem_we=0, mem_addr=ptr; hold until mem_gnt, then go to RLAT.
  - RLAT: mem_rdata valid, registered into the decoder; go to CHK.
  - CHK: sample decoder sec/ded/dout.
    - ded=1: increment ded_cnt, pulse ded_irq, log ded_addr if none logged; go to NEXT with no write.
    - sec=1: increment sec_cnt; go to ENC.
    - Otherwise go to NEXT.
  - ENC: corrected data into the encoder; go to WR.
  - WR: mem_req=1, mem_we=1, mem_wdata=encoder dout; hold until mem_gnt, then go to NEXT.
  - NEXT:
    - If ptr == DEPTH-1: ptr=0 and pulse pass_done; otherwise ptr+1.
    - Then: if scrub_en go to WAIT, else go to IDLE.
- Snoop hazard: a flag sets on snp_wr && snp_addr==ptr from the granted read cycle up to and including the WR grant cycle. If set, write-back is abandoned (WR goes straight to NEXT without access). sec_cnt is still incremented. The flag clears in NEXT.
- Request outputs: mem_req/mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and mem_gnt=0.
- scrub_en deasserted mid-word: the current word completes through NEXT, then the FSM goes to IDLE. The pointer is retained, so scrubbing resumes at the next address.
- Counters saturate at all-ones.
- cnt_clr: same-cycle clear takes priority over an increment. A DED in that cycle is dropped from the count but ded_irq still pulses.
- ded_addr log: held until cnt_clr. A "logged" flag distinguishes a logged address 0 from an empty log.
- Reset mid-access: mem_req drops the next cycle; no partial write is possible because mem_we is only meaningful with a grant.

Decomposition:
- Package cbb_ecc_pkg holds:
  - state enum scrub_st_e (IDLE, WAIT, RD, RLAT, CHK, ENC, WR, NEXT);
  - localparam CW = DW+EW.
- Sub-modules: reuse the existing cbb_ecc_dec and cbb_ecc_enc. No new sub-module.

Test Plan:
- DEPTH=4, INTERVAL=2, clean memory, mem_gnt tied 1 → 4 reads at addresses 0,1,2,3, no writes, pass_done pulses once after address 3; sec_cnt=0, ded_cnt=0; successive reads spaced 6 cycles apart.
- Word 2 preloaded with bit 17 flipped → one write to address 2 with the correct codeword; sec_cnt=1; memory word 2 reads back clean on the next pass.
- Word 1 with bits 3 and 40 flipped → no write, ded_irq pulses once, ded_cnt=1, ded_addr=1. On the second pass ded_cnt=2 and ded_addr stays 1.
- mem_gnt held 0 for 5 cycles during RD and again during WR → outputs stable throughout; exactly one read and one write occur.
- SEC word at address 3 with snp_wr to address 3 asserted in the CHK cycle → write-back suppressed, sec_cnt increments.
- cnt_clr asserted in the same cycle as a SEC increment with sec_cnt=0xFFFF → sec_cnt=0. Separately, forced saturation stays at 0xFFFF.
